// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// stage-state encoding, payload widths and packed field offsets per boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_st_e;

  localparam int ID_EX_W  = 160;
  localparam int EXE_MEM_W = 133;
  localparam int MEM_WB_W = 104;

  // EXE/MEM: pc | alu | store data | pc+4 | rd
  localparam int EM_PC_LSB   = 0;
  localparam int EM_ALU_LSB  = 32;
  localparam int EM_WD_LSB   = 64;
  localparam int EM_PC4_LSB  = 96;
  localparam int EM_RD_LSB   = 128;

  // MEM/WB: alu | load data | pc+4 | rd | ctrl
  localparam int MW_ALU_LSB  = 0;
  localparam int MW_RD_LSB   = 32;
  localparam int MW_PC4_LSB  = 64;
  localparam int MW_RDI_LSB  = 96;
  localparam int MW_CTRL_LSB = 101;

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload register of an elastic stage.
// Clear wins over load so a killed entry always reads as zero.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXE_MEM_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ld,
  input  logic              zero,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)       q <= '0;
    else if (zero) q <= '0;
    else if (ld)   q <= d;
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready stage register with flush and bubble zeroing.
// DEPTH=1 plain register, DEPTH=2 skid buffer; PIPE_STAGE_PERF_EN adds counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXE_MEM_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] o_q;

  // flush kills both directions of transfer
  assign in_fire  = in_valid && in_ready && !flush;
  assign out_fire = out_valid && out_ready && !flush;
  assign out_data = out_valid ? o_q : '0;

  if (DEPTH == 1) begin : g_reg
    logic vld_q;

    pipe_skid_entry #(.DATA_W(DATA_W)) u_out (
      .clk  (clk),
      .clr  (clr),
      .ld   (in_fire),
      .zero (flush || (out_fire && !in_fire)),
      .d    (in_data),
      .q    (o_q)
    );

    always_ff @(posedge clk or posedge clr) begin
      if (clr)           vld_q <= 1'b0;
      else if (flush)    vld_q <= 1'b0;
      else if (in_fire)  vld_q <= 1'b1;
      else if (out_fire) vld_q <= 1'b0;
    end

    assign out_valid = vld_q;
    assign in_ready  = !vld_q || out_ready;
    assign count     = {1'b0, vld_q};

  end else if (DEPTH == 2) begin : g_skid
    stage_st_e         st_q;
    logic              rdy_q;
    logic              o_ld;
    logic              o_zero;
    logic              s_ld;
    logic              s_zero;
    logic [DATA_W-1:0] o_d;
    logic [DATA_W-1:0] s_q;

    always_comb begin
      o_ld   = 1'b0;
      o_zero = 1'b0;
      s_ld   = 1'b0;
      s_zero = 1'b0;
      o_d    = in_data;
      unique case (st_q)
        EMPTY: o_ld = in_fire;
        HALF: begin
          o_ld   = in_fire && out_fire;
          s_ld   = in_fire && !out_fire;
          o_zero = out_fire && !in_fire;
        end
        FULL: begin
          o_ld   = out_fire;
          o_d    = s_q;
          s_zero = out_fire;
        end
        default: ;
      endcase
      if (flush) begin
        o_zero = 1'b1;
        s_zero = 1'b1;
      end
    end

    pipe_skid_entry #(.DATA_W(DATA_W)) u_out (
      .clk  (clk),
      .clr  (clr),
      .ld   (o_ld),
      .zero (o_zero),
      .d    (o_d),
      .q    (o_q)
    );

    pipe_skid_entry #(.DATA_W(DATA_W)) u_skid (
      .clk  (clk),
      .clr  (clr),
      .ld   (s_ld),
      .zero (s_zero),
      .d    (in_data),
      .q    (s_q)
    );

    // in_ready comes straight from rdy_q, cutting the upstream ready path
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        st_q  <= EMPTY;
        rdy_q <= 1'b1;
      end else if (flush) begin
        st_q  <= EMPTY;
        rdy_q <= 1'b1;
      end else begin
        unique case (st_q)
          EMPTY: if (in_fire) st_q <= HALF;
          HALF: begin
            if (in_fire && !out_fire) begin
              st_q  <= FULL;
              rdy_q <= 1'b0;
            end else if (out_fire && !in_fire) begin
              st_q <= EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              st_q  <= HALF;
              rdy_q <= 1'b1;
            end
          end
          default: begin
            st_q  <= EMPTY;
            rdy_q <= 1'b1;
          end
        endcase
      end
    end

    assign out_valid = (st_q != EMPTY);
    assign in_ready  = rdy_q;
    assign count     = st_q;

  end else begin : g_bad
    $fatal(1, "pipe_stage_elastic: DEPTH must be 1 or 2");
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && (count != 2'd0)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a DEPTH=2 and a DEPTH=1 instance checked
// every cycle against queue-based models, plus directed literal checks.
module tb_pipe_stage_elastic;

  localparam int W  = 133;
  localparam int W1 = 8;

  logic          clk;
  logic          clr;
  logic          flush;
  logic          iv;
  logic [W-1:0]  id;
  logic          ordy;
  logic          rdy;
  logic          ov;
  logic [W-1:0]  odat;
  logic [1:0]    cnt;
  logic          iv1;
  logic [W1-1:0] id1;
  logic          ordy1;
  logic          rdy1;
  logic          ov1;
  logic [W1-1:0] od1;
  logic [1:0]    cnt1;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   p_stall;
  logic [31:0]   p_flush;
  logic [31:0]   p_stall1;
  logic [31:0]   p_flush1;
  int unsigned   m_stall;
  int unsigned   m_flush;
`endif

  int checks = 0;
  int failures = 0;
  bit started = 0;

  logic [W-1:0]  q2[$];
  logic [W1-1:0] q1[$];

  pipe_stage_elastic #(.DATA_W(W), .DEPTH(2)) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (iv),
    .in_ready  (rdy),
    .in_data   (id),
    .out_valid (ov),
    .out_ready (ordy),
    .out_data  (odat),
    .count     (cnt)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt (p_stall),
    .perf_flush_cnt (p_flush)
`endif
  );

  pipe_stage_elastic #(.DATA_W(W1), .DEPTH(1)) dut1 (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (iv1),
    .in_ready  (rdy1),
    .in_data   (id1),
    .out_valid (ov1),
    .out_ready (ordy1),
    .out_data  (od1),
    .count     (cnt1)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt (p_stall1),
    .perf_flush_cnt (p_flush1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q2.delete();
    q1.delete();
`ifdef PIPE_STAGE_PERF_EN
    m_stall = 0;
    m_flush = 0;
`endif
  endtask

  // one clock edge of the reference: queues of held payloads per instance
  task automatic model_step();
    bit r2, v2, r1, v1;
    if (clr) begin
      model_reset();
      return;
    end
    r2 = q2.size() < 2;
    v2 = q2.size() != 0;
    r1 = (q1.size() == 0) || ordy1;
    v1 = q1.size() != 0;
`ifdef PIPE_STAGE_PERF_EN
    if (v2 && !ordy) m_stall++;
    if (flush && q2.size() != 0) m_flush++;
`endif
    if (flush) begin
      q2.delete();
      q1.delete();
    end else begin
      if (v2 && ordy) void'(q2.pop_front());
      if (iv && r2) q2.push_back(id);
      if (v1 && ordy1) void'(q1.pop_front());
      if (iv1 && r1) q1.push_back(id1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [W-1:0]  e_od;
    logic [W1-1:0] e_od1;
    forever begin
      @(negedge clk);
      if (started && !clr) begin
        e_od = '0;
        if (q2.size() != 0) e_od = q2[0];
        e_od1 = '0;
        if (q1.size() != 0) e_od1 = q1[0];
        chk("m2_valid", W'(ov), W'(q2.size() != 0));
        chk("m2_data", odat, e_od);
        chk("m2_count", W'(cnt), W'(q2.size()));
        chk("m2_ready", W'(rdy), W'(q2.size() < 2));
        chk("m1_valid", W'(ov1), W'(q1.size() != 0));
        chk("m1_data", W'(od1), W'(e_od1));
        chk("m1_count", W'(cnt1), W'(q1.size()));
        chk("m1_ready", W'(rdy1), W'((q1.size() == 0) || ordy1));
`ifdef PIPE_STAGE_PERF_EN
        chk("m_stall", W'(p_stall), W'(m_stall));
        chk("m_flush", W'(p_flush), W'(m_flush));
`endif
      end
    end
  end

  initial begin
    logic [159:0] r;
    clr = 0; flush = 0; iv = 0; id = '0; ordy = 0;
    iv1 = 0; id1 = '0; ordy1 = 0;
    model_reset();
    #1 clr = 1;
    #1;
    chk("rst_data", odat, '0);
    chk("rst_ready", W'(rdy), W'(1));
    chk("rst_count", W'(cnt), W'(0));
    chk("rst_ready1", W'(rdy1), W'(1));
    tick();
    tick();
    #1 clr = 0;
    started = 1;

    // mid-cycle clr while holding a payload
    iv = 1; id = W'(9);
    tick();
    iv = 0;
    #2 clr = 1;
    model_reset();
    #1;
    chk("clr_valid", W'(ov), W'(0));
    chk("clr_data", odat, '0);
    chk("clr_ready", W'(rdy), W'(1));
    chk("clr_count", W'(cnt), W'(0));
    clr = 0;

    iv = 1; id = W'(1); iv1 = 1; id1 = 8'h1;
    tick();
    iv = 0; iv1 = 0;
    chk("fill_valid", W'(ov), W'(1));
    chk("fill_data", odat, W'(1));
    chk("fill_count", W'(cnt), W'(1));
    chk("fill_data1", W'(od1), W'(1));
    ordy = 1; ordy1 = 1;
    tick();

`ifdef PIPE_STAGE_PERF_EN
    #2 clr = 1;
    model_reset();
    #1 clr = 0;
    ordy = 0; iv = 1; id = W'(17);
    tick();
    iv = 0;
    tick(); tick(); tick();
    ordy = 1; flush = 1;
    tick();
    tick();
    flush = 0;
    chk("perf_stall", W'(p_stall), W'(3));
    chk("perf_flush", W'(p_flush), W'(1));
    #2 clr = 1;
    model_reset();
    #1;
    chk("perf_stall_clr", W'(p_stall), W'(0));
    chk("perf_flush_clr", W'(p_flush), W'(0));
    clr = 0;
`endif

    // backpressure into the skid entry
    ordy = 0; iv = 1; id = W'(32'hA);
    tick();
    id = W'(32'hB);
    tick();
    id = W'(32'hC);
    chk("bp_count", W'(cnt), W'(2));
    chk("bp_ready", W'(rdy), W'(0));
    chk("bp_head", odat, W'(32'hA));
    ordy = 1;
    tick();
    chk("bp_second", odat, W'(32'hB));
    tick();
    chk("bp_third", odat, W'(32'hC));
    iv = 0;
    tick();
    chk("bp_drained", W'(ov), W'(0));

    // streaming
    iv = 1; ordy = 1;
    for (int i = 0; i < 100; i++) begin
      id = W'(i + 1);
      tick();
      chk("stream_data", odat, W'(i + 1));
      chk("stream_count", W'(cnt), W'(1));
      chk("stream_ready", W'(rdy), W'(1));
    end
    iv = 0;
    tick();

    // flush beats simultaneous in/out transfers
    ordy = 0; iv = 1; id = W'(5);
    tick();
    id = W'(6);
    tick();
    chk("fl_full", W'(cnt), W'(2));
    flush = 1; id = W'(7); ordy = 1;
    tick();
    flush = 0; iv = 0;
    chk("fl_count", W'(cnt), W'(0));
    chk("fl_valid", W'(ov), W'(0));
    chk("fl_data", odat, '0);
    tick(); tick();
    chk("fl_after", W'(ov), W'(0));

    // DEPTH=1 combinational ready and replace-on-transfer
    ordy1 = 0; iv1 = 1; id1 = 8'h3;
    tick();
    iv1 = 0;
    chk("d1_valid", W'(ov1), W'(1));
    chk("d1_ready_lo", W'(rdy1), W'(0));
    chk("d1_data3", W'(od1), W'(8'h3));
    #2 ordy1 = 1;
    #1;
    chk("d1_ready_hi", W'(rdy1), W'(1));
    iv1 = 1; id1 = 8'h4;
    tick();
    iv1 = 0;
    chk("d1_data4", W'(od1), W'(8'h4));
    chk("d1_count", W'(cnt1), W'(1));
    tick();

    // random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      iv    = ($urandom % 10) < 7;
      id    = r[W-1:0];
      ordy  = ($urandom % 10) < 6;
      flush = ($urandom % 100) < 4;
      iv1   = ($urandom % 10) < 6;
      id1   = W1'($urandom);
      ordy1 = ($urandom % 10) < 5;
      tick();
    end
    flush = 0; iv = 0; iv1 = 0; ordy = 1; ordy1 = 1;
    tick(); tick(); tick();
    chk("end_empty", W'(cnt), W'(0));
    chk("end_empty1", W'(cnt1), W'(0));

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic inter-stage pipeline register: the generic replacement for the fixed-width, always-advancing stage registers between EXE/MEM/WB.
- Adds valid/ready handshake (stall), synchronous flush, bubble-safe output zeroing and an optional 2-entry skid buffer that breaks the combinational ready path.
- Instantiated once per stage boundary; the payload is a packed bus whose layout is defined by the enclosing stage.

Parameters:
- DATA_W, 133, payload width in bits (≥1).
- DEPTH, 2, buffer entries: 1 = single register (combinational ready); 2 = skid buffer (registered ready). Any other value is a fatal elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries (branch/jump taken).
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage accepts the payload this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  payload; all-zero whenever out_valid=0.
- count  output  2  entries held (0..DEPTH).

Behaviour:
- Reset (clr=1, async): count=0, out_valid=0, out_data=0, in_ready=1, all storage zeroed; takes effect immediately; the first edge after release behaves as from EMPTY.
- Transfer in: in_valid && in_ready at an edge. Transfer out: out_valid && out_ready at an edge.
- Latency: 1 cycle from accepted input to out_valid. Throughput: 1 per cycle in both DEPTH modes.
- Ordering is strict FIFO. Payloads are never duplicated or dropped except by flush or clr.
- DEPTH=1:
  - in_ready = !out_valid || out_ready (combinational).
  - Simultaneous in/out transfers replace the register contents.
- DEPTH=2, states EMPTY / HALF / FULL:
  - in_ready = (state != FULL), driven directly from a flop.
  - EMPTY: in → HALF.
  - HALF: in and no out → FULL (new payload goes to the skid entry); in and out → HALF (register takes the new payload); out only → EMPTY.
  - FULL: out → HALF (skid entry moves to the output register); no out → FULL. Input is ignored because in_ready=0.
- Flush (flush=1 at an edge):
  - Next state is EMPTY, count=0, out_valid=0, out_data=0.
  - The in_valid payload of that cycle is discarded even if in_ready=1; upstream treats the cycle as consumed.
  - Flush has priority over any simultaneous transfer.
  - A flush while out_ready=1 does not count as a downstream transfer of the killed entry.
- Bubble safety: out_data is forced to 0 when out_valid=0. All control bits (RegWrite, MemWrite, Jump, ...) therefore read inactive without consumer gating.
- Holding (out_valid=1, out_ready=0): out_data and out_valid stay stable; in_data changes have no effect.
- in_data is captured only on an accepted transfer. X on in_data while in_valid=0 must never propagate.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] (cycles with out_valid && !out_ready) and perf_flush_cnt[31:0] (edges with flush=1 and count≠0).
  - Both counters are cleared by clr and wrap at 2^32.
- Undefined: these ports and all counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - Stage-state encoding (EMPTY=2'd0, HALF=2'd1, FULL=2'd2).
  - Payload-width constants per boundary (e.g. EXE_MEM_W=133) and the field-offset constants for each packed layout.
- One natural sub-module, pipe_skid_entry: a single DATA_W register with load enable and clear, instantiated twice for DEPTH=2 (output register + skid register).

Test Plan:
- Reset/fill: assert clr mid-cycle, release; push 0x1 → next cycle out_valid=1, out_data=0x1, count=1. During clr, out_data=0 and in_ready=1 with no clock edge.
- Backpressure, DEPTH=2: out_ready=0, push A=0xA, B=0xB → count=2, in_ready=0 on the cycle after B, in_data=0xC ignored. Then out_ready=1 → outputs A then B then 0xC (only if re-presented), in order, no loss.
- Streaming: in_valid=1 and out_ready=1 for 100 cycles with an incrementing payload → 1 output per cycle after 1-cycle latency, count stays 1, in_ready never drops.
- Flush priority: state FULL (0x5, 0x6), flush=1 with in_valid=1 in_data=0x7 and out_ready=1 → next cycle count=0, out_valid=0, out_data=0. 0x5, 0x6 and 0x7 never appear.
- DEPTH=1 combinational ready: out_valid=1, out_ready toggled 0→1 within a cycle → in_ready follows the same cycle. Simultaneous in/out replaces the payload 0x3→0x4 with count=1.
- PIPE_STAGE_PERF_EN: 3 cycles held with out_ready=0, then 2 flushes (one while EMPTY) → perf_stall_cnt=3, perf_flush_cnt=1. clr → both read 0.
